// File: rtl/seq_alu_pkg.sv
// Shared types for the sequential ALU: opcodes, controller states and the
// multiply/divide engine mode, plus the iteration-counter sizing helper.
package seq_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_NOT = 3'd5,
    OP_MUL = 3'd6,
    OP_DIV = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic {
    MD_MUL = 1'b0,
    MD_DIV = 1'b1
  } md_mode_e;

  // Counter must hold the value W itself, hence clog2(W+1).
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative W-step engine: shift-add multiply or restoring divide.
// done is high during the final step; result is that step's outcome.
module seq_alu_muldiv
  import seq_alu_pkg::*;
#(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  md_mode_e       mode,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [2*W-1:0] result
);

  localparam int CW = cnt_width(W);

  logic          busy_reg;
  md_mode_e      mode_reg;
  logic [W-1:0]  opnd_reg;
  logic [W-1:0]  hi_reg;
  logic [W-1:0]  lo_reg;
  logic [CW-1:0] cnt_reg;

  logic [W-1:0]  hi_next;
  logic [W-1:0]  lo_next;
  logic [W:0]    mul_sum;
  logic [W:0]    div_shift;
  logic          div_ge;

  // MUL: hi/lo form the product shift register, lo starts as the multiplier.
  // DIV: hi is the partial remainder, lo shifts dividend out / quotient in.
  assign mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : '0);
  assign div_shift = {hi_reg, lo_reg[W-1]};
  assign div_ge    = (div_shift >= {1'b0, opnd_reg});

  always_comb begin
    hi_next = hi_reg;
    lo_next = lo_reg;
    if (mode_reg == MD_MUL) begin
      hi_next = mul_sum[W:1];
      lo_next = {mul_sum[0], lo_reg[W-1:1]};
    end else begin
      // The true difference is below the divisor, so W-bit arithmetic is exact.
      hi_next = div_ge ? (div_shift[W-1:0] - opnd_reg) : div_shift[W-1:0];
      lo_next = {lo_reg[W-2:0], div_ge};
    end
  end

  assign done   = busy_reg && (cnt_reg == CW'(1));
  assign result = {hi_next, lo_next};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_reg <= 1'b0;
      mode_reg <= MD_MUL;
      opnd_reg <= '0;
      hi_reg   <= '0;
      lo_reg   <= '0;
      cnt_reg  <= '0;
    end else if (start && !busy_reg) begin
      busy_reg <= 1'b1;
      mode_reg <= mode;
      opnd_reg <= (mode == MD_MUL) ? a : b;
      hi_reg   <= '0;
      lo_reg   <= (mode == MD_MUL) ? b : a;
      cnt_reg  <= CW'(W);
    end else if (busy_reg) begin
      hi_reg  <= hi_next;
      lo_reg  <= lo_next;
      cnt_reg <= cnt_reg - CW'(1);
      if (cnt_reg == CW'(1)) begin
        busy_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshakes. Single-cycle ops finish in one
// cycle; MUL and non-trivial DIV run W iterations in seq_alu_muldiv.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [2:0]     op,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] result,
  output logic           zero,
  output logic           carry,
  output logic           dz
);

  state_e         state_reg, state_next;
  logic [2*W-1:0] result_reg, result_next;
  logic           zero_reg, zero_next;
  logic           carry_reg, carry_next;
  logic           dz_reg, dz_next;

  op_e            op_cur;
  logic [W:0]     add_sum;
  logic [2*W-1:0] sub_diff;
  logic [W-1:0]   and_w, or_w, xor_w;
  logic [2*W-1:0] quick_result;
  logic           quick_carry;
  logic           quick_dz;
  logic           needs_iter;

  logic           md_start;
  md_mode_e       md_mode;
  logic           md_done;
  logic [2*W-1:0] md_result;

  assign op_cur   = op_e'(op);
  assign add_sum  = {1'b0, a} + {1'b0, b};
  assign sub_diff = {{W{1'b0}}, a} - {{W{1'b0}}, b};

  for (genvar gi = 0; gi < W; gi++) begin : g_logic
    assign and_w[gi] = a[gi] & b[gi];
    assign or_w[gi]  = a[gi] | b[gi];
    assign xor_w[gi] = a[gi] ^ b[gi];
  end

  always_comb begin
    quick_result = '0;
    quick_carry  = 1'b0;
    quick_dz     = 1'b0;
    case (op_cur)
      OP_ADD: begin
        quick_result = {{(W-1){1'b0}}, add_sum};
        quick_carry  = add_sum[W];
      end
      OP_SUB: begin
        quick_result = sub_diff;
        quick_carry  = (a < b);
      end
      OP_AND:  quick_result = {{W{1'b0}}, and_w};
      OP_OR:   quick_result = {{W{1'b0}}, or_w};
      OP_XOR:  quick_result = {{W{1'b0}}, xor_w};
      OP_NOT:  quick_result = {~b, ~a};
      OP_DIV:  quick_dz     = (b == '0);
      default: quick_result = '0;
    endcase
  end

  // Divide-by-zero short-circuits to DONE with a zero result.
  assign needs_iter = (op_cur == OP_MUL) || ((op_cur == OP_DIV) && (b != '0));
  assign md_mode    = (op_cur == OP_DIV) ? MD_DIV : MD_MUL;

  always_comb begin
    state_next  = state_reg;
    result_next = result_reg;
    zero_next   = zero_reg;
    carry_next  = carry_reg;
    dz_next     = dz_reg;
    md_start    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (in_valid) begin
          if (needs_iter) begin
            state_next = ST_EXEC;
            md_start   = 1'b1;
          end else begin
            state_next  = ST_DONE;
            result_next = quick_result;
            zero_next   = (quick_result == '0);
            carry_next  = quick_carry;
            dz_next     = quick_dz;
          end
        end
      end
      ST_EXEC: begin
        if (md_done) begin
          state_next  = ST_DONE;
          result_next = md_result;
          zero_next   = (md_result == '0);
          carry_next  = 1'b0;
          dz_next     = 1'b0;
        end
      end
      ST_DONE: begin
        // Return through IDLE so a new request can never overlap a handshake.
        if (out_ready) begin
          state_next  = ST_IDLE;
          result_next = '0;
          zero_next   = 1'b0;
          carry_next  = 1'b0;
          dz_next     = 1'b0;
        end
      end
      default: begin
        state_next  = ST_IDLE;
        result_next = '0;
        zero_next   = 1'b0;
        carry_next  = 1'b0;
        dz_next     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      result_reg <= '0;
      zero_reg   <= 1'b0;
      carry_reg  <= 1'b0;
      dz_reg     <= 1'b0;
    end else begin
      state_reg  <= state_next;
      result_reg <= result_next;
      zero_reg   <= zero_next;
      carry_reg  <= carry_next;
      dz_reg     <= dz_next;
    end
  end

  seq_alu_muldiv #(
    .W(W)
  ) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (md_start),
    .mode   (md_mode),
    .a      (a),
    .b      (b),
    .done   (md_done),
    .result (md_result)
  );

  assign in_ready  = (state_reg == ST_IDLE);
  assign out_valid = (state_reg == ST_DONE);
  assign result    = result_reg;
  assign zero      = zero_reg;
  assign carry     = carry_reg;
  assign dz        = dz_reg;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (W=4): vector table for every opcode plus
// hand sequences for output hold/backpressure and reset during MUL.
module tb_seq_alu;

  localparam int W = 4;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [2:0]     op;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] result;
  logic           zero;
  logic           carry;
  logic           dz;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] res;
    logic       c;
    logic       z;
    logic       d;
    int         lat;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  seq_alu #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .carry     (carry),
    .dz        (dz)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int n;
    int lat;
    logic rdy_low;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    op        = v.op;
    a         = v.a;
    b         = v.b;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    lat      = 1;
    rdy_low  = 1'b1;
    while (!out_valid && lat < 40) begin
      if (in_ready) rdy_low = 1'b0;
      tick();
      lat++;
    end
    if (in_ready) rdy_low = 1'b0;
    $display("txn %0d op=%0d a=%0d b=%0d result=%02h carry=%0b zero=%0b dz=%0b lat=%0d",
             idx, v.op, v.a, v.b, result, carry, zero, dz, lat);
    chk($sformatf("v%0d_latency", idx), lat, v.lat);
    chk($sformatf("v%0d_result", idx), result, v.res);
    chk($sformatf("v%0d_carry", idx), carry, v.c);
    chk($sformatf("v%0d_zero", idx), zero, v.z);
    chk($sformatf("v%0d_dz", idx), dz, v.d);
    chk($sformatf("v%0d_busy_ready", idx), rdy_low, 1'b1);
    tick();
    chk($sformatf("v%0d_ov_clear", idx), out_valid, 1'b0);
  endtask

  initial begin
    int seen;

    //          op    a      b      res    c     z     dz    lat
    vecs[0]  = '{3'd0, 4'd15, 4'd15, 8'h1E, 1'b1, 1'b0, 1'b0, 1};
    vecs[1]  = '{3'd1, 4'd3,  4'd5,  8'hFE, 1'b1, 1'b0, 1'b0, 1};
    vecs[2]  = '{3'd1, 4'd7,  4'd7,  8'h00, 1'b0, 1'b1, 1'b0, 1};
    vecs[3]  = '{3'd2, 4'd12, 4'd10, 8'h08, 1'b0, 1'b0, 1'b0, 1};
    vecs[4]  = '{3'd3, 4'd12, 4'd10, 8'h0E, 1'b0, 1'b0, 1'b0, 1};
    vecs[5]  = '{3'd4, 4'd12, 4'd10, 8'h06, 1'b0, 1'b0, 1'b0, 1};
    vecs[6]  = '{3'd5, 4'd3,  4'd5,  8'hAC, 1'b0, 1'b0, 1'b0, 1};
    vecs[7]  = '{3'd6, 4'd15, 4'd15, 8'hE1, 1'b0, 1'b0, 1'b0, 5};
    vecs[8]  = '{3'd6, 4'd0,  4'd9,  8'h00, 1'b0, 1'b1, 1'b0, 5};
    vecs[9]  = '{3'd7, 4'd13, 4'd4,  8'h13, 1'b0, 1'b0, 1'b0, 5};
    vecs[10] = '{3'd7, 4'd9,  4'd0,  8'h00, 1'b0, 1'b1, 1'b1, 1};
    vecs[11] = '{3'd7, 4'd15, 4'd1,  8'h0F, 1'b0, 1'b0, 1'b0, 5};
    vecs[12] = '{3'd7, 4'd3,  4'd7,  8'h30, 1'b0, 1'b0, 1'b0, 5};
    vecs[13] = '{3'd0, 4'd0,  4'd0,  8'h00, 1'b0, 1'b1, 1'b0, 1};
    vecs[14] = '{3'd6, 4'd3,  4'd5,  8'h0F, 1'b0, 1'b0, 1'b0, 5};
    vecs[15] = '{3'd1, 4'd0,  4'd15, 8'hF1, 1'b1, 1'b0, 1'b0, 1};
    vecs[16] = '{3'd0, 4'd8,  4'd7,  8'h0F, 1'b0, 1'b0, 1'b0, 1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    op        = '0;
    tick();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_result", result, 8'h00);
    chk("rst_flags", {zero, carry, dz}, 3'b000);

    for (int i = 0; i < NV; i++) begin
      run_vec(vecs[i], i);
    end

    // Backpressure: result held while out_ready is low, new requests ignored.
    op = 3'd0; a = 4'd1; b = 4'd2; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    op = 3'd1; a = 4'd15; b = 4'd1;
    for (int i = 0; i < 3; i++) begin
      chk("hold_out_valid", out_valid, 1'b1);
      chk("hold_result", result, 8'h03);
      chk("hold_in_ready", in_ready, 1'b0);
      tick();
    end
    $display("txn hold op=0 a=1 b=2 result=%02h out_valid=%0b", result, out_valid);
    out_ready = 1'b1;
    chk("hold_result_pre_hs", result, 8'h03);
    tick();
    chk("hs_out_valid", out_valid, 1'b0);
    chk("hs_no_bypass_ready", in_ready, 1'b1);
    chk("hs_result_cleared", result, 8'h00);
    in_valid = 1'b0;
    tick();
    chk("hs_idle_out_valid", out_valid, 1'b0);

    // Reset two cycles into a MUL: the operation must vanish.
    op = 3'd6; a = 4'd15; b = 4'd15; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_in_ready", in_ready, 1'b1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) seen++;
    end
    $display("txn abort op=6 a=15 b=15 out_valid_cycles=%0d", seen);
    chk("abort_no_result", seen, 0);
    chk("abort_ready_after", in_ready, 1'b1);

    run_vec(vecs[9], 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
